// File: rtl/tqvp_uart_pkg.sv
// Shared types and default sizing for the tqvp UART receive path.
package tqvp_uart_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } rx_state_t;

  localparam int unsigned PAYLOAD_BITS_DFLT    = 8;
  localparam int unsigned FIFO_DEPTH_LOG2_DFLT = 2;
  localparam int unsigned FIFO_DEPTH           = 1 << FIFO_DEPTH_LOG2_DFLT;
  localparam int unsigned LEVEL_W              = FIFO_DEPTH_LOG2_DFLT + 1;

endpackage

// File: rtl/tqvp_uart_rx_fifo_mem.sv
// Receive FIFO storage: register array, synchronous write, combinational read, no data reset.
module tqvp_uart_rx_fifo_mem
  import tqvp_uart_pkg::*;
#(
  parameter int unsigned DATA_W = PAYLOAD_BITS_DFLT,
  parameter int unsigned ADDR_W = FIFO_DEPTH_LOG2_DFLT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned ENTRIES = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tqvp_uart_rx_fifo_ctrl.sv
// Drains bytes from tqvp_uart_rx into a FWFT FIFO for the CPU; withholds the ack when full.
// Optional UART_RX_FIFO_THRESH_EN adds irq_thresh and a level-threshold interrupt.
module tqvp_uart_rx_fifo_ctrl
  import tqvp_uart_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS    = PAYLOAD_BITS_DFLT,
  parameter int unsigned FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DFLT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [PAYLOAD_BITS-1:0]   rx_data,
  output logic                      rx_read,
  input  logic                      cpu_rd,
  input  logic                      flush,
  output logic [PAYLOAD_BITS-1:0]   cpu_data,
  output logic [FIFO_DEPTH_LOG2:0]  fifo_level,
  output logic                      fifo_empty,
  output logic                      fifo_full,
  output logic                      rx_stalled,
  output logic                      irq
`ifdef UART_RX_FIFO_THRESH_EN
  ,
  input  logic [FIFO_DEPTH_LOG2:0]  irq_thresh
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;

  rx_state_t               state;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [LVL_W-1:0]        level;
  logic [PAYLOAD_BITS-1:0] head;
  logic                    push;
  logic                    pop;
  logic                    wr_en;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(DEPTH));
  assign fifo_level = level;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = (state == S_IDLE) && rx_valid && (!fifo_full || cpu_rd);
  assign pop        = cpu_rd && !fifo_empty;
  assign wr_en      = push && !flush && !reset;
  assign rx_stalled = (state == S_IDLE) && rx_valid && fifo_full && !cpu_rd;
  assign cpu_data   = fifo_empty ? '0 : head;

  tqvp_uart_rx_fifo_mem #(
    .DATA_W (PAYLOAD_BITS),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Flush clears storage state only; an ack already in flight still completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      rx_read <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (push) begin
            state   <= S_ACK;
            rx_read <= 1'b1;
          end
        end
        S_ACK: begin
          state   <= S_IDLE;
          rx_read <= 1'b0;
        end
      endcase

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      level <= level + LVL_W'(1);
        else if (pop && !push) level <= level - LVL_W'(1);
      end
    end
  end

`ifdef UART_RX_FIFO_THRESH_EN
  logic [LVL_W-1:0] thresh_eff;

  // Zero behaves as one; anything above the depth saturates at the depth.
  always_comb begin
    thresh_eff = irq_thresh;
    if (irq_thresh == '0)                  thresh_eff = LVL_W'(1);
    else if (irq_thresh > LVL_W'(DEPTH))   thresh_eff = LVL_W'(DEPTH);
  end

  assign irq = (level >= thresh_eff);
`else
  assign irq = !fifo_empty;
`endif

endmodule

// File: tb/tb_tqvp_uart_rx_fifo_ctrl.sv
// Randomized scoreboard bench for tqvp_uart_rx_fifo_ctrl; honours UART_RX_FIFO_THRESH_EN.
`timescale 1ns/1ps
module tb_tqvp_uart_rx_fifo_ctrl;
  import tqvp_uart_pkg::*;

  localparam int D    = int'(FIFO_DEPTH);
  localparam int LW   = int'(LEVEL_W);
  localparam int NCYC = 1400;

  typedef struct packed {
    logic          rx_read;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          stalled;
    logic          irq;
    logic [7:0]    data;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_read;
  logic          cpu_rd;
  logic          flush;
  logic [7:0]    cpu_data;
  logic [LW-1:0] fifo_level;
  logic          fifo_empty;
  logic          fifo_full;
  logic          rx_stalled;
  logic          irq;
`ifdef UART_RX_FIFO_THRESH_EN
  logic [LW-1:0] irq_thresh;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state: queued bytes and whether an ack is currently showing.
  logic [7:0] mq[$];
  bit         ack;
  bit         pending;
  bit         prev_rd;

  tqvp_uart_rx_fifo_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_read    (rx_read),
    .cpu_rd     (cpu_rd),
    .flush      (flush),
    .cpu_data   (cpu_data),
    .fifo_level (fifo_level),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .rx_stalled (rx_stalled),
    .irq        (irq)
`ifdef UART_RX_FIFO_THRESH_EN
    ,
    .irq_thresh (irq_thresh)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic irq_model(input int lvl);
`ifdef UART_RX_FIFO_THRESH_EN
    int t;
    t = int'(irq_thresh);
    if (t == 0) t = 1;
    if (t > D) t = D;
    return lvl >= t;
`else
    return lvl != 0;
`endif
  endfunction

  // Monitor: compare every presented output set against the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rx_read",    32'(rx_read),    32'(mon_e.rx_read));
      chk("fifo_level", 32'(fifo_level), 32'(mon_e.level));
      chk("fifo_empty", 32'(fifo_empty), 32'(mon_e.empty));
      chk("fifo_full",  32'(fifo_full),  32'(mon_e.full));
      chk("rx_stalled", 32'(rx_stalled), 32'(mon_e.stalled));
      chk("irq",        32'(irq),        32'(mon_e.irq));
      chk("cpu_data",   32'(cpu_data),   32'(mon_e.data));
    end
  end

  // Stimulus: a receiver that holds each byte until acked, plus CPU pops, flushes, resets.
  initial begin
    int   ph;
    int   byte_pct;
    int   rd_pct;
    int   fl_pct;
    bit   r;
    bit   rd;
    bit   fl;
    bit   acc;
    bit   pop_m;
    exp_t e;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cpu_rd   = 1'b0;
    flush    = 1'b0;
`ifdef UART_RX_FIFO_THRESH_EN
    irq_thresh = LW'(3);
`endif
    ack     = 1'b0;
    pending = 1'b0;
    prev_rd = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      ph = c / 350;
      case (ph)
        0:       begin byte_pct = 30; rd_pct = 30; fl_pct = 0; end
        1:       begin byte_pct = 90; rd_pct = 6;  fl_pct = 0; end
        2:       begin byte_pct = 60; rd_pct = 40; fl_pct = 3; end
        default: begin byte_pct = 70; rd_pct = 30; fl_pct = 2; end
      endcase
      r  = (c < 3) || (ph >= 3 && $urandom_range(0, 99) == 0);
      rd = !prev_rd && (c > 4) && ($urandom_range(0, 99) < rd_pct);
      fl = ($urandom_range(0, 99) < fl_pct);

      if (r) begin
        rx_valid = 1'b0;
        pending  = 1'b0;
      end else if (ack) begin
        pending = 1'b0;
      end else if (!pending) begin
        if (c == 3 || $urandom_range(0, 99) < byte_pct) begin
          rx_valid = 1'b1;
          rx_data  = (c == 3) ? 8'hA5 : 8'($urandom);
          pending  = 1'b1;
        end else begin
          rx_valid = 1'b0;
        end
      end
`ifdef UART_RX_FIFO_THRESH_EN
      if ($urandom_range(0, 39) == 0) irq_thresh = LW'($urandom_range(0, (1 << LW) - 1));
`endif
      reset   = r;
      cpu_rd  = rd;
      flush   = fl;
      prev_rd = rd;

      // Model the coming edge from the behavioural rules.
      if (r) begin
        mq.delete();
        ack = 1'b0;
      end else begin
        acc   = !ack && rx_valid && (mq.size() < D || rd);
        pop_m = rd && mq.size() > 0;
        if (fl) mq.delete();
        else begin
          if (pop_m) void'(mq.pop_front());
          if (acc)   mq.push_back(rx_data);
        end
        ack = acc;
      end

      e.rx_read = ack;
      e.level   = LW'(mq.size());
      e.empty   = (mq.size() == 0);
      e.full    = (mq.size() == D);
      e.stalled = !ack && rx_valid && (mq.size() == D) && !rd;
      e.irq     = irq_model(mq.size());
      e.data    = (mq.size() == 0) ? 8'h00 : mq[0];
      exp_q.push_back(e);
    end

    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
